// File: rtl/scan_seq_pkg.sv
// Shared types and constants for the scan sequencer: FSM state encoding and
// slot geometry for the 2-to-4 decoder drive.
package scan_seq_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // True for the states in which a sweep is in progress.
  function automatic logic is_busy_state(input state_t st);
    return (st == ST_DWELL) || (st == ST_BLANK);
  endfunction

endpackage

// File: rtl/scan_next_slot.sv
// Combinational search for the next enabled slot after cur_idx, circularly.
// wrap is set when the search had to pass the top slot to find it.
module scan_next_slot
  import scan_seq_pkg::*;
(
  input  logic [SLOT_W-1:0]    cur_idx,
  input  logic [NUM_SLOTS-1:0] slot_mask,
  output logic [SLOT_W-1:0]    nxt_idx,
  output logic                 wrap
);

  logic [SLOT_W:0] sum_s;
  logic            found_s;

  // First set mask bit strictly after cur_idx, searching upward then wrapping.
  always_comb begin
    nxt_idx = cur_idx;
    wrap    = 1'b0;
    found_s = 1'b0;
    sum_s   = {(SLOT_W + 1){1'b0}};
    for (int i = 1; i <= NUM_SLOTS; i++) begin
      sum_s = {1'b0, cur_idx} + (SLOT_W + 1)'(i);
      if (!found_s && slot_mask[sum_s[SLOT_W-1:0]]) begin
        found_s = 1'b1;
        nxt_idx = sum_s[SLOT_W-1:0];
        wrap    = sum_s[SLOT_W];
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Sweeps a 2-to-4 decoder across the enabled slots, dwelling on each for a
// programmable number of cycles with a one-cycle blank between slots.
module scan_sequencer
  import scan_seq_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [3:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               en,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done
);

  state_t                 state_r, state_s;
  logic [SLOT_W-1:0]      slot_r, slot_s;
  logic [NUM_SLOTS-1:0]   mask_r, mask_s;
  logic                   cont_r, cont_s;
  logic [DWELL_W-1:0]     dwell_r, dwell_s;
  logic [DWELL_W-1:0]     cnt_r, cnt_s;
  logic                   en_r, busy_r, done_r;

  logic [SLOT_W-1:0]      ns_cur_s, ns_nxt_s;
  logic [NUM_SLOTS-1:0]   ns_mask_s;
  logic                   ns_wrap_s;

  // Counter reload for a dwell value; zero behaves as one active cycle.
  function automatic logic [DWELL_W-1:0] reload_of(input logic [DWELL_W-1:0] d);
    if (d == {DWELL_W{1'b0}}) begin
      return {DWELL_W{1'b0}};
    end else begin
      return d - {{(DWELL_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // In IDLE, searching after the top slot yields the lowest set bit of the
  // incoming mask, so one search unit serves both start and slot advance.
  assign ns_cur_s  = (state_r == ST_IDLE) ? {SLOT_W{1'b1}} : slot_r;
  assign ns_mask_s = (state_r == ST_IDLE) ? mask : mask_r;

  scan_next_slot u_next_slot (
    .cur_idx   (ns_cur_s),
    .slot_mask (ns_mask_s),
    .nxt_idx   (ns_nxt_s),
    .wrap      (ns_wrap_s)
  );

  // Next-state, slot and dwell-counter logic.
  always_comb begin
    state_s = state_r;
    slot_s  = slot_r;
    mask_s  = mask_r;
    cont_s  = cont_r;
    dwell_s = dwell_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !stop) begin
          mask_s  = mask;
          cont_s  = cont;
          dwell_s = dwell;
          cnt_s   = reload_of(dwell);
          if (mask != 4'b0000) begin
            state_s = ST_DWELL;
            slot_s  = ns_nxt_s;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DWELL: begin
        if (stop) begin
          state_s = ST_IDLE;
        end else if (cnt_r == {DWELL_W{1'b0}}) begin
          state_s = ST_BLANK;
        end else begin
          cnt_s = cnt_r - {{(DWELL_W-1){1'b0}}, 1'b1};
        end
      end
      ST_BLANK: begin
        if (stop) begin
          state_s = ST_IDLE;
        end else if (ns_wrap_s && !cont_r) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DWELL;
          slot_s  = ns_nxt_s;
          cnt_s   = reload_of(dwell_r);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, captured configuration and registered decoder/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      slot_r  <= {SLOT_W{1'b0}};
      mask_r  <= {NUM_SLOTS{1'b0}};
      cont_r  <= 1'b0;
      dwell_r <= {DWELL_W{1'b0}};
      cnt_r   <= {DWELL_W{1'b0}};
      en_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      slot_r  <= slot_s;
      mask_r  <= mask_s;
      cont_r  <= cont_s;
      dwell_r <= dwell_s;
      cnt_r   <= cnt_s;
      en_r    <= (state_s == ST_DWELL);
      busy_r  <= is_busy_state(state_s);
      done_r  <= (state_s == ST_DONE);
    end
  end

  assign en   = en_r;
  assign a    = slot_r[1];
  assign b    = slot_r[0];
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed self-checking bench for scan_sequencer; outputs are checked as the
// packed vector {en, a, b, busy, done} one time unit after each rising edge.
module tb_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, cont;
  logic [3:0] mask;
  logic [7:0] dwell;
  logic       en, a, b, busy, done;

  int tests = 0;
  int fails = 0;

  scan_sequencer #(.DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .cont  (cont),
    .mask  (mask),
    .dwell (dwell),
    .en    (en),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] expv);
    logic [4:0] obs;
    obs = {en, a, b, busy, done};
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed={en,a,b,busy,done}=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Expected outputs in cycle c of a mask=1111 single sweep with dwell d>0.
  function automatic logic [4:0] exp_full(input int c, input int d);
    int k, pos;
    logic [1:0] kk;
    if (c <= 4 * (d + 1)) begin
      k   = (c - 1) / (d + 1);
      pos = (c - 1) % (d + 1);
      kk  = 2'(k);
      return {(pos < d) ? 1'b1 : 1'b0, kk, 1'b1, 1'b0};
    end else if (c == 4 * (d + 1) + 1) begin
      return 5'b0_11_0_1;
    end else begin
      return 5'b0_11_0_0;
    end
  endfunction

  // Full sweep, optionally with a reconfiguring start pulse during slot 2.
  task automatic sweep_full(input bit inject, input string name);
    mask  = 4'b1111;
    dwell = 8'd2;
    cont  = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      start = 1'b0;
      chk($sformatf("%s c%0d", name, c), exp_full(c, 2));
      if (inject && c == 7) begin
        start = 1'b1;
        mask  = 4'b0001;
        dwell = 8'd0;
        cont  = 1'b1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    cont  = 1'b0;
    mask  = 4'b0000;
    dwell = 8'd0;

    // Reset state
    tick();
    tick();
    chk("reset", 5'b0_00_0_0);
    rst_n = 1'b1;
    tick();
    chk("idle after reset", 5'b0_00_0_0);

    // Single sweep over all slots, dwell 2
    sweep_full(1'b0, "sweep1111");

    // Empty mask: immediate done, never busy
    mask  = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mask0 done", 5'b0_11_0_1);
    tick();
    chk("mask0 idle", 5'b0_11_0_0);

    // Continuous sweep of slots 1 and 3 with dwell 0, then stop in DWELL
    mask  = 4'b1010;
    dwell = 8'd0;
    cont  = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      start = 1'b0;
      chk($sformatf("cont c%0d", c),
          {((c - 1) % 2 == 0) ? 1'b1 : 1'b0,
           (((c - 1) / 2) % 2 == 1) ? 2'b11 : 2'b01, 1'b1, 1'b0});
    end
    stop = 1'b1;
    tick();
    chk("stop", 5'b0_01_0_0);
    stop = 1'b0;
    tick();
    chk("stop idle", 5'b0_01_0_0);

    // Start during DWELL of slot 2 with a new configuration is ignored
    sweep_full(1'b1, "ignore");

    // Reset during slot 1 DWELL
    mask  = 4'b1111;
    dwell = 8'd3;
    cont  = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
    end
    chk("pre-reset slot1", 5'b1_01_1_0);
    rst_n = 1'b0;
    tick();
    chk("mid reset", 5'b0_00_0_0);
    rst_n = 1'b1;
    tick();
    chk("post reset", 5'b0_00_0_0);

    // Sweep after reset: single slot 2, dwell 1
    mask  = 4'b0100;
    dwell = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("single dwell", 5'b1_10_1_0);
    tick();
    chk("single blank", 5'b0_10_1_0);
    tick();
    chk("single done", 5'b0_10_0_1);
    tick();
    chk("single idle", 5'b0_10_0_0);

    // start and stop together in IDLE: stop wins
    mask  = 4'b1111;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    chk("start+stop", 5'b0_10_0_0);
    start = 1'b0;
    stop  = 1'b0;
    tick();
    chk("start+stop idle", 5'b0_10_0_0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter: DWELL_W, 8, width of the per-slot dwell count.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  single-cycle request to begin a sweep; sampled only in IDLE.
REQ-005 Port: stop  input  1  abort request; sampled every cycle.
REQ-006 Port: cont  input  1  1 = continuous sweeping, 0 = single sweep; captured with start.
REQ-007 Port: mask  input  4  slot enable, bit i = 1 includes slot i; captured with start.
REQ-008 Port: dwell  input  DWELL_W  active cycles per slot; captured with start; value 0 treated as 1.
REQ-009 Port: en  output  1  enable to the downstream 2-to-4 decoder.
REQ-010 Port: a  output  1  slot index MSB to the decoder.
REQ-011 Port: b  output  1  slot index LSB to the decoder.
REQ-012 Port: busy  output  1  high while in DWELL or BLANK.
REQ-013 Port: done  output  1  single-cycle pulse at the end of a completed single sweep.

Function
REQ-014 The block SHALL register all outputs; no output is combinational from an input.
REQ-015 States SHALL be IDLE, DWELL, BLANK, DONE.
REQ-016 IDLE: en=0, busy=0, done=0; {a,b} hold their last value.
REQ-017 IDLE with start=1, stop=0 and mask!=0 SHALL capture cont/mask/dwell and enter DWELL on the lowest set mask bit; en=1 on the first cycle after start is sampled.
REQ-018 IDLE with start=1 and mask=0 SHALL go to DONE (done pulse, no en activity).
REQ-019 DWELL: en=1, {a,b}=slot index (a=MSB), busy=1; held for max(dwell,1) cycles, then BLANK.
REQ-020 BLANK: exactly 1 cycle, en=0, {a,b} unchanged, busy=1 (anti-ghosting gap).
REQ-021 After BLANK, the block SHALL enter DWELL on the next higher set mask bit; slots with mask bit 0 are skipped with no cycles spent.
REQ-022 After BLANK of the highest set slot: cont=1 -> wrap to the lowest set slot (DWELL); cont=0 -> DONE.
REQ-023 DONE: done=1 for exactly one cycle, busy=0, en=0, then IDLE.
REQ-024 start while busy SHALL be ignored; captured cont/mask/dwell SHALL NOT change mid-sweep.
REQ-025 stop=1 in DWELL or BLANK SHALL force IDLE on the next edge (en=0, busy=0) with no done pulse.
REQ-026 start and stop both 1 in IDLE: stop wins, the block remains in IDLE.
REQ-027 Single sweep with N set slots and effective dwell D: en active N*D cycles, BLANK N cycles, done on cycle N*(D+1)+1 after the start sample.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force IDLE, en=0, a=0, b=0, busy=0, done=0, dwell counter=0, captured registers=0.
REQ-029 Reset mid-sweep SHALL take effect on that edge with no done pulse; rst_n has priority over start and stop.

Structure
REQ-030 Shared package scan_seq_pkg SHALL hold the state enum, NUM_SLOTS=4 and SLOT_W=2.
REQ-031 Sub-module scan_next_slot (combinational: current index + mask -> next set index + wrap flag) SHALL be instantiated once.
REQ-032 Outputs en, a and b SHALL connect directly to the en, a and b inputs of the 2-to-4 decoder.

Verification
REQ-033 mask=1111, dwell=2, cont=0, start at edge 0 -> en high in cycles 1-2 (ab=00), 4-5 (01), 7-8 (10), 10-11 (11); en low in 3, 6, 9, 12; done=1 in cycle 13 only.
REQ-034 mask=1010, dwell=0, cont=1 -> slot 1 then slot 3, each 1 active cycle + 1 blank, repeating; no done pulse; stop -> en=0, busy=0 next cycle.
REQ-035 mask=0000, start -> done pulse on the next cycle, en never asserted, busy stays 0.
REQ-036 start pulse during DWELL of slot 2, with a new mask -> ignored; sweep continues with the original mask.
REQ-037 rst_n=0 during slot 1 DWELL -> all outputs 0 on that edge; no done; a new start after reset sweeps normally.
REQ-038 start and stop both asserted in IDLE -> no activity; busy and en remain 0.
